// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle: ALU, load and link requesters plus the decode-side
// issue marker that feeds the pending-write scoreboard.
interface regfile_write_arbiter_if #(
  parameter int REGBITS = 5,
  parameter int WIDTH   = 32
);

  logic               alu_valid;
  logic               alu_ready;
  logic [REGBITS-1:0] alu_dest;
  logic [WIDTH-1:0]   alu_data;

  logic               ld_valid;
  logic               ld_ready;
  logic [REGBITS-1:0] ld_dest;
  logic [WIDTH-1:0]   ld_data;

  logic               lnk_valid;
  logic               lnk_ready;
  logic [WIDTH-1:0]   lnk_data;

  logic               issue_valid;
  logic [REGBITS-1:0] issue_dest;

  // Requester / decode side.
  modport master (
    output alu_valid, alu_dest, alu_data,
    input  alu_ready,
    output ld_valid, ld_dest, ld_data,
    input  ld_ready,
    output lnk_valid, lnk_data,
    input  lnk_ready,
    output issue_valid, issue_dest
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_dest, alu_data,
    output alu_ready,
    input  ld_valid, ld_dest, ld_data,
    output ld_ready,
    input  lnk_valid, lnk_data,
    output lnk_ready,
    input  issue_valid, issue_dest
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter. Picks one of link / ALU / load writebacks per
// cycle, registers the chosen write towards the register file and keeps a
// per-register pending-write scoreboard. A starving ALU result is promoted
// above the load path once it has waited AGE_LIMIT cycles.
module regfile_write_arbiter #(
  parameter int REGBITS   = 5,
  parameter int WIDTH     = 32,
  parameter int AGE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_arbiter_if.slave    wb,
  output logic                      regWriteEn,
  output logic                      RaWriteEn,
  output logic [REGBITS-1:0]        Rdest,
  output logic [WIDTH-1:0]          writeData,
  output logic [(2**REGBITS)-1:0]   busy
);

  localparam int NREGS   = 2 ** REGBITS;
  localparam int AGE_RAW = $clog2(AGE_LIMIT + 1);
  localparam int AGE_W   = (AGE_RAW < 1) ? 1 : AGE_RAW;

  localparam logic [REGBITS-1:0] LINK_REG  = REGBITS'(31);
  localparam logic [AGE_W-1:0]   AGE_MAX   = AGE_W'(AGE_LIMIT);

  // Registered state.
  logic [AGE_W-1:0]   age_q, age_d;
  logic               reg_we_q, reg_we_d;
  logic               ra_we_q, ra_we_d;
  logic [REGBITS-1:0] rdest_q, rdest_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [NREGS-1:0]   busy_q, busy_d;

  // Grant decode.
  logic alu_aged;
  logic lnk_gnt;
  logic alu_gnt;
  logic ld_gnt;

  // Scoreboard masks.
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic             xfer;
  logic [REGBITS-1:0] xfer_dest;

  // Fixed-priority grant: link, then an aged ALU, then load, then ALU.
  always_comb begin
    alu_aged = wb.alu_valid && (age_q == AGE_MAX);
    lnk_gnt  = !reset && wb.lnk_valid;
    alu_gnt  = !reset && wb.alu_valid && !wb.lnk_valid && (alu_aged || !wb.ld_valid);
    ld_gnt   = !reset && wb.ld_valid && !wb.lnk_valid && !alu_aged;
  end

  assign wb.lnk_ready = lnk_gnt;
  assign wb.alu_ready = alu_gnt;
  assign wb.ld_ready  = ld_gnt;

  // ALU wait counter: counts stalled cycles, saturates, clears when idle or granted.
  always_comb begin
    age_d = age_q;
    if (!wb.alu_valid || alu_gnt) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Next write towards the register file; address/data hold when idle.
  always_comb begin
    reg_we_d  = 1'b0;
    ra_we_d   = 1'b0;
    rdest_d   = rdest_q;
    wdata_d   = wdata_q;
    xfer      = 1'b0;
    xfer_dest = '0;
    if (lnk_gnt) begin
      ra_we_d   = 1'b1;
      rdest_d   = LINK_REG;
      wdata_d   = wb.lnk_data;
      xfer      = 1'b1;
      xfer_dest = LINK_REG;
    end else if (alu_gnt) begin
      // Writes to register 0 are accepted but never enabled.
      reg_we_d  = (wb.alu_dest != '0);
      rdest_d   = wb.alu_dest;
      wdata_d   = wb.alu_data;
      xfer      = 1'b1;
      xfer_dest = wb.alu_dest;
    end else if (ld_gnt) begin
      reg_we_d  = (wb.ld_dest != '0);
      rdest_d   = wb.ld_dest;
      wdata_d   = wb.ld_data;
      xfer      = 1'b1;
      xfer_dest = wb.ld_dest;
    end
  end

  // Scoreboard update: clear the written register, then set newly issued one (set wins).
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (xfer) begin
      clr_mask[xfer_dest] = 1'b1;
    end
    if (wb.issue_valid && (wb.issue_dest != '0)) begin
      set_mask[wb.issue_dest] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q    <= '0;
      reg_we_q <= 1'b0;
      ra_we_q  <= 1'b0;
      rdest_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      age_q    <= age_d;
      reg_we_q <= reg_we_d;
      ra_we_q  <= ra_we_d;
      rdest_q  <= rdest_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign regWriteEn = reg_we_q;
  assign RaWriteEn  = ra_we_q;
  assign Rdest      = rdest_q;
  assign writeData  = wdata_q;
  assign busy       = busy_q;

  // Requesters must hold valid and payload until accepted.
  alu_hold_a : assert property (@(posedge clk) disable iff (reset)
    (wb.alu_valid && !wb.alu_ready) |=>
      (wb.alu_valid && $stable(wb.alu_dest) && $stable(wb.alu_data)));

  ld_hold_a : assert property (@(posedge clk) disable iff (reset)
    (wb.ld_valid && !wb.ld_ready) |=>
      (wb.ld_valid && $stable(wb.ld_dest) && $stable(wb.ld_data)));

  lnk_hold_a : assert property (@(posedge clk) disable iff (reset)
    (wb.lnk_valid && !wb.lnk_ready) |=>
      (wb.lnk_valid && $stable(wb.lnk_data)));

  one_ready_a : assert property (@(posedge clk)
    $onehot0({wb.alu_ready, wb.ld_ready, wb.lnk_ready}));

  one_we_a : assert property (@(posedge clk) !(regWriteEn && RaWriteEn));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the arbitration
// rules.
module tb_regfile_write_arbiter;

  localparam int REGBITS   = 5;
  localparam int WIDTH     = 32;
  localparam int AGE_LIMIT = 3;

  logic                 clk;
  logic                 reset;
  logic                 regWriteEn;
  logic                 RaWriteEn;
  logic [REGBITS-1:0]   Rdest;
  logic [WIDTH-1:0]     writeData;
  logic [31:0]          busy;

  regfile_write_arbiter_if #(.REGBITS(REGBITS), .WIDTH(WIDTH)) wb ();

  regfile_write_arbiter #(
    .REGBITS  (REGBITS),
    .WIDTH    (WIDTH),
    .AGE_LIMIT(AGE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb),
    .regWriteEn(regWriteEn),
    .RaWriteEn (RaWriteEn),
    .Rdest     (Rdest),
    .writeData (writeData),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. Grant codes: 0 none, 1 link, 2 ALU, 3 load.
  bit        m_regwe;
  bit        m_rawe;
  bit [4:0]  m_rdest;
  bit [31:0] m_wdata;
  bit [31:0] m_busy;
  int        m_wait;
  int        last_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (reset) return 0;
    if (wb.lnk_valid) return 1;
    if (wb.alu_valid && m_wait >= AGE_LIMIT) return 2;
    if (wb.ld_valid) return 3;
    if (wb.alu_valid) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_regwe = 0; m_rawe = 0; m_rdest = 0; m_wdata = 0; m_busy = 0; m_wait = 0;
  endtask

  task automatic model_edge(input int g);
    int clr;
    clr = -1;
    m_regwe = 0;
    m_rawe  = 0;
    if (g == 1) begin
      m_rawe = 1; m_rdest = 31; m_wdata = wb.lnk_data; clr = 31;
    end else if (g == 2) begin
      m_regwe = (wb.alu_dest != 0); m_rdest = wb.alu_dest; m_wdata = wb.alu_data;
      clr = int'(wb.alu_dest);
    end else if (g == 3) begin
      m_regwe = (wb.ld_dest != 0); m_rdest = wb.ld_dest; m_wdata = wb.ld_data;
      clr = int'(wb.ld_dest);
    end
    if (clr >= 0) m_busy[clr] = 1'b0;
    if (wb.issue_valid && wb.issue_dest != 0) m_busy[wb.issue_dest] = 1'b1;
    m_busy[0] = 1'b0;
    if (!wb.alu_valid || g == 2) m_wait = 0;
    else if (m_wait < AGE_LIMIT) m_wait++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".regWriteEn"}, 64'(regWriteEn), 64'(m_regwe));
    check({tag, ".RaWriteEn"},  64'(RaWriteEn),  64'(m_rawe));
    check({tag, ".Rdest"},      64'(Rdest),      64'(m_rdest));
    check({tag, ".writeData"},  64'(writeData),  64'(m_wdata));
    check({tag, ".busy"},       64'(busy),       64'(m_busy));
    check({tag, ".we_excl"},    64'(regWriteEn & RaWriteEn), 64'(0));
  endtask

  // One clock: readys checked before the edge, registered outputs after it.
  // Entered and left at the falling edge.
  task automatic cycle(input string tag);
    int g;
    #1;
    g = model_grant();
    check({tag, ".lnk_ready"}, 64'(wb.lnk_ready), 64'(g == 1));
    check({tag, ".alu_ready"}, 64'(wb.alu_ready), 64'(g == 2));
    check({tag, ".ld_ready"},  64'(wb.ld_ready),  64'(g == 3));
    @(posedge clk);
    model_edge(g);
    #1;
    check_outputs(tag);
    last_grant = g;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wb.alu_valid = 0; wb.alu_dest = 0; wb.alu_data = 0;
    wb.ld_valid = 0;  wb.ld_dest = 0;  wb.ld_data = 0;
    wb.lnk_valid = 0; wb.lnk_data = 0;
    wb.issue_valid = 0; wb.issue_dest = 0;
  endtask

  initial begin
    int alu_cycle;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    last_grant = 0;

    // Reset values appear before any clock edge.
    #3;
    check_outputs("reset_async");
    check("reset.alu_ready", 64'(wb.alu_ready), 64'(0));
    wb.alu_valid = 1; wb.ld_valid = 1; wb.lnk_valid = 1;
    #1;
    check("reset.readys", 64'({wb.alu_ready, wb.ld_ready, wb.lnk_ready}), 64'(0));
    clear_inputs();
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // Single ALU write.
    wb.alu_valid = 1; wb.alu_dest = 5; wb.alu_data = 32'hDEADBEEF;
    cycle("alu_single");
    check("alu_single.Rdest5", 64'(Rdest), 64'(5));
    check("alu_single.data", 64'(writeData), 64'h0DEADBEEF);
    wb.alu_valid = 0;
    cycle("alu_single_idle");

    // Three-way contention: link, load, ALU on consecutive edges.
    wb.lnk_valid = 1; wb.lnk_data = 32'h0000_1234;
    wb.ld_valid = 1;  wb.ld_dest = 7; wb.ld_data = 32'h7777_0007;
    wb.alu_valid = 1; wb.alu_dest = 9; wb.alu_data = 32'h9999_0009;
    cycle("contend1");
    check("contend1.Ra", 64'({RaWriteEn, Rdest}), 64'({1'b1, 5'd31}));
    wb.lnk_valid = 0;
    cycle("contend2");
    check("contend2.ld", 64'({regWriteEn, Rdest}), 64'({1'b1, 5'd7}));
    wb.ld_valid = 0;
    cycle("contend3");
    check("contend3.alu", 64'({regWriteEn, Rdest}), 64'({1'b1, 5'd9}));
    wb.alu_valid = 0;
    cycle("contend_idle");

    // Aging: ALU overtakes a continuous load stream after AGE_LIMIT waits.
    alu_cycle = 0;
    wb.ld_valid = 1; wb.ld_dest = 1; wb.ld_data = $urandom;
    wb.alu_valid = 1; wb.alu_dest = 2; wb.alu_data = 32'hA5A5_0002;
    for (int i = 1; i <= 6; i++) begin
      cycle("aging");
      if (last_grant == 3) begin
        wb.ld_dest = 5'($urandom_range(1, 30)); wb.ld_data = $urandom;
      end else if (last_grant == 2) begin
        alu_cycle = i; wb.alu_valid = 0;
      end
    end
    check("aging.alu_cycle", 64'(alu_cycle), 64'(4));
    wb.ld_valid = 0;
    cycle("aging_idle");

    // Scoreboard set/clear interaction.
    wb.issue_valid = 1; wb.issue_dest = 12;
    cycle("sb_issue12");
    check("sb_issue12.bit", 64'(busy[12]), 64'(1));
    wb.issue_dest = 0;
    cycle("sb_issue0");
    check("sb_issue0.bit0", 64'(busy[0]), 64'(0));
    wb.issue_dest = 12;
    wb.ld_valid = 1; wb.ld_dest = 12; wb.ld_data = 32'h0C0C_0C0C;
    cycle("sb_set_wins");
    check("sb_set_wins.bit", 64'(busy[12]), 64'(1));
    wb.issue_valid = 0; wb.ld_valid = 0;
    wb.alu_valid = 1; wb.alu_dest = 12; wb.alu_data = 32'h1212_1212;
    cycle("sb_clear");
    check("sb_clear.bit", 64'(busy[12]), 64'(0));
    wb.alu_valid = 0;

    // Destination register 0 write is dropped.
    wb.alu_valid = 1; wb.alu_dest = 0; wb.alu_data = 32'h1;
    cycle("dest0");
    check("dest0.we", 64'({regWriteEn, RaWriteEn}), 64'(0));
    wb.alu_valid = 0;

    // Reset mid-operation, between edges, with a write and busy bits pending.
    wb.ld_valid = 1; wb.ld_dest = 3; wb.ld_data = 32'h3333_3333;
    wb.issue_valid = 1; wb.issue_dest = 20;
    cycle("pre_reset");
    check("pre_reset.we", 64'(regWriteEn), 64'(1));
    check("pre_reset.busy20", 64'(busy[20]), 64'(1));
    wb.ld_valid = 0; wb.issue_valid = 0;
    wb.alu_valid = 1; wb.alu_dest = 8; wb.alu_data = 32'h8888_0008;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("mid_reset");
    check("mid_reset.alu_ready", 64'(wb.alu_ready), 64'(0));
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cycle("post_reset");
    check("post_reset.alu", 64'({regWriteEn, Rdest}), 64'({1'b1, 5'd8}));
    wb.alu_valid = 0;
    cycle("post_reset_idle");

    // Random traffic; requesters hold payload until granted.
    clear_inputs();
    last_grant = 0;
    for (int i = 0; i < 400; i++) begin
      if (wb.lnk_valid) begin
        if (last_grant == 1) begin
          wb.lnk_valid = 1'($urandom_range(0, 1)); wb.lnk_data = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        wb.lnk_valid = 1; wb.lnk_data = $urandom;
      end
      if (wb.alu_valid) begin
        if (last_grant == 2) begin
          wb.alu_valid = 1'($urandom_range(0, 1));
          wb.alu_dest = 5'($urandom); wb.alu_data = $urandom;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        wb.alu_valid = 1; wb.alu_dest = 5'($urandom); wb.alu_data = $urandom;
      end
      if (wb.ld_valid) begin
        if (last_grant == 3) begin
          wb.ld_valid = ($urandom_range(0, 3) != 0);
          wb.ld_dest = 5'($urandom); wb.ld_data = $urandom;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        wb.ld_valid = 1; wb.ld_dest = 5'($urandom); wb.ld_data = $urandom;
      end
      wb.issue_valid = 1'($urandom_range(0, 1));
      wb.issue_dest  = 5'($urandom);
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter REGBITS, default 5, register address width.
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL have parameter AGE_LIMIT, default 3, ALU wait cycles before ALU outranks load.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 alu_valid/alu_ready  input/output  1/1  ALU writeback handshake.
REQ-007 alu_dest/alu_data  input  REGBITS/WIDTH  ALU destination register and result.
REQ-008 ld_valid/ld_ready  input/output  1/1  load writeback handshake.
REQ-009 ld_dest/ld_data  input  REGBITS/WIDTH  load destination register and data.
REQ-010 lnk_valid/lnk_ready  input/output  1/1  link (return-address) write handshake.
REQ-011 lnk_data  input  WIDTH  return address, always written to register 31.
REQ-012 issue_valid/issue_dest  input  1/REGBITS  decode marks a register as pending-write.
REQ-013 regWriteEn, RaWriteEn  output  1 each  registered write enables to the register file.
REQ-014 Rdest/writeData  output  REGBITS/WIDTH  registered write address and data.
REQ-015 busy  output  2**REGBITS  per-register pending-write scoreboard, registered.

Function
REQ-016 Transfer SHALL occur at a rising edge where valid and ready are both 1; at most one ready SHALL be 1 per cycle.
REQ-017 Ready SHALL be combinational from current valids and age counter; ready SHALL be 0 when its valid is 0.
REQ-018 Priority SHALL be: link > ALU-if-aged (age==AGE_LIMIT) > load > ALU.
REQ-019 ALU age counter SHALL increment each cycle alu_valid=1 and alu_ready=0, saturate at AGE_LIMIT, clear to 0 on ALU transfer or when alu_valid=0.
REQ-020 On ALU/load transfer: next cycle regWriteEn=1, RaWriteEn=0, Rdest=dest, writeData=data (latency 1 edge; register file commits on following falling edge).
REQ-021 On link transfer: next cycle RaWriteEn=1, regWriteEn=0, Rdest=31, writeData=lnk_data.
REQ-022 Transfer with dest 0 SHALL be accepted but produce regWriteEn=0 (write dropped); Rdest/writeData still updated.
REQ-023 Without a transfer, regWriteEn and RaWriteEn SHALL be 0 next cycle; Rdest/writeData hold.
REQ-024 regWriteEn and RaWriteEn SHALL never both be 1.
REQ-025 issue_valid with issue_dest!=0 SHALL set busy[issue_dest] at next edge; busy[0] SHALL always be 0.
REQ-026 Transfer SHALL clear busy[dest] (busy[31] for link) at the same edge the write is registered.
REQ-027 Simultaneous set and clear of same register SHALL leave busy=1 (set wins).
REQ-028 Requester SHALL hold valid and payload stable until transfer; violation is flagged by a simulation assertion, not handled.
REQ-029 Back-to-back transfers SHALL be sustained: one write per cycle with continuous valids.

Reset
REQ-030 Reset SHALL force regWriteEn=0, RaWriteEn=0, Rdest=0, writeData=0, busy=0, age=0 asynchronously, without waiting for clk.
REQ-031 All readys SHALL be 0 while reset=1; a transfer in progress at reset assertion SHALL be discarded.
REQ-032 First transfer SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-033 Single ALU: alu_valid=1, dest=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle regWriteEn=1, Rdest=5, writeData=0xDEADBEEF; then regWriteEn=0.
REQ-034 Contention: link, load(dest 7), ALU(dest 9) all valid -> grants link, load, ALU on three consecutive edges; RaWriteEn then regWriteEn twice, Rdest 31,7,9.
REQ-035 Aging: ld_valid held continuously with new payloads, alu_valid=1 -> ALU granted on 4th cycle (after 3 waits), then load resumes.
REQ-036 Scoreboard: issue dest 12 -> busy[12]=1; later load transfer dest 12 in same cycle as new issue dest 12 -> busy[12] stays 1; issue dest 0 -> busy[0]=0.
REQ-037 Dest 0: ALU dest 0, data 0x1 -> alu_ready=1, next cycle regWriteEn=0, RaWriteEn=0.
REQ-038 Reset mid-operation: assert reset between edges while regWriteEn=1, busy nonzero -> outputs and busy 0 before next edge; after release, pending valid granted at first edge.
